// File: rtl/idr_fu.sv
// Iterative radix-2 restoring divide/remainder unit for RV32M DIV/DIVU/REM/REMU.
// Optional leading-zero early exit is enabled by defining IDRFU_EARLY_EXIT_EN.
package idr_fu_pkg;
   localparam int unsigned RSZ = 32;
   typedef enum logic [1:0] {
      DIV  = 2'd0,
      DIVU = 2'd1,
      REM  = 2'd2,
      REMU = 2'd3
   } IDR_OP_TYPE;
endpackage

module idr_fu
   import idr_fu_pkg::*;
#(
   parameter int unsigned DW    = RSZ,
   parameter int unsigned CNT_W = $clog2(DW + 1)
) (
   input  logic            clk_in,
   input  logic            reset_n,
   input  logic            flush,
   input  logic            start,
   input  IDR_OP_TYPE      op,
   input  logic [DW-1:0]   Rs1_data,
   input  logic [DW-1:0]   Rs2_data,
   output logic [DW-1:0]   quotient,
   output logic [DW-1:0]   remainder,
   output logic            done,
   output logic            busy
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;
   typedef enum logic [1:0] {FX_NORM, FX_DIVZ, FX_OVF} fix_t;

   localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};

   state_t             state_q, state_d;
   fix_t               fix_q;
   logic [DW-1:0]      acc_q, dvd_q, dvs_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               neg_q, neg_r;

   // Operand decode for the capture in IDLE
   logic               signed_op, div_zero, ovf;
   logic [DW-1:0]      mag1, mag2;

   always_comb begin
      signed_op = (op == DIV) || (op == REM);
      mag1      = (signed_op && Rs1_data[DW-1]) ? (~Rs1_data) + DW'(1) : Rs1_data;
      mag2      = (signed_op && Rs2_data[DW-1]) ? (~Rs2_data) + DW'(1) : Rs2_data;
      div_zero  = (Rs2_data == '0);
      ovf       = signed_op && (Rs1_data == MIN_NEG) && (Rs2_data == '1);
   end

`ifdef IDRFU_EARLY_EXIT_EN
   function automatic logic [CNT_W-1:0] clz(input logic [DW-1:0] v);
      clz = CNT_W'(DW);
      for (int i = 0; i < int'(DW); i++)
         if (v[i]) clz = CNT_W'(int'(DW) - 1 - i);
   endfunction

   logic [CNT_W-1:0] lz;
   assign lz = clz(mag1);
`endif

   // State register
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic; flush overrides everything
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               if (div_zero || ovf) state_d = S_FIX;
`ifdef IDRFU_EARLY_EXIT_EN
               else if (mag1 == '0) state_d = S_FIX;
`endif
               else                 state_d = S_CALC;
            end
         end
         S_CALC:  if (cnt_q == CNT_W'(1)) state_d = S_FIX;
         S_FIX:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (flush) state_d = S_IDLE;
   end

   // One restoring step: shift {acc,dvd}, trial-subtract at DW+1 bits
   logic [DW:0]    rem_sh, trial;
   logic           q_bit;
   logic [DW-1:0]  acc_n, dvd_n;

   always_comb begin
      rem_sh = {acc_q, dvd_q[DW-1]};
      trial  = rem_sh - {1'b0, dvs_q};
      q_bit  = ~trial[DW];
      acc_n  = q_bit ? trial[DW-1:0] : rem_sh[DW-1:0];
      dvd_n  = {dvd_q[DW-2:0], q_bit};
   end

   // Final result selection, sign fix-up and special cases
   logic [DW-1:0]  quo_c, rem_c;

   always_comb begin
      quo_c = dvd_q;
      rem_c = acc_q;
      unique case (fix_q)
         FX_DIVZ: begin
            quo_c = '1;
            rem_c = dvd_q;
         end
         FX_OVF: begin
            quo_c = MIN_NEG;
            rem_c = '0;
         end
         default: begin
            quo_c = neg_q ? (~dvd_q) + DW'(1) : dvd_q;
            rem_c = neg_r ? (~acc_q) + DW'(1) : acc_q;
         end
      endcase
   end

   // Datapath and registered outputs
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         acc_q     <= '0;
         dvd_q     <= '0;
         dvs_q     <= '0;
         cnt_q     <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         fix_q     <= FX_NORM;
         quotient  <= '0;
         remainder <= '0;
         done      <= 1'b0;
         busy      <= 1'b0;
      end else begin
         done <= 1'b0;
         busy <= (state_d != S_IDLE);
         if (!flush) begin
            unique case (state_q)
               S_IDLE: begin
                  if (start) begin
                     neg_q <= signed_op & (Rs1_data[DW-1] ^ Rs2_data[DW-1]);
                     neg_r <= signed_op & Rs1_data[DW-1];
                     dvs_q <= mag2;
                     acc_q <= '0;
                     fix_q <= div_zero ? FX_DIVZ : (ovf ? FX_OVF : FX_NORM);
`ifdef IDRFU_EARLY_EXIT_EN
                     dvd_q <= div_zero ? Rs1_data : (mag1 << lz);
                     cnt_q <= CNT_W'(DW) - lz;
`else
                     dvd_q <= div_zero ? Rs1_data : mag1;
                     cnt_q <= CNT_W'(DW);
`endif
                  end
               end
               S_CALC: begin
                  acc_q <= acc_n;
                  dvd_q <= dvd_n;
                  cnt_q <= cnt_q - CNT_W'(1);
               end
               S_FIX: begin
                  quotient  <= quo_c;
                  remainder <= rem_c;
                  done      <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_idr_fu.sv
// Directed self-checking bench for idr_fu (DW=32); latency expectations follow IDRFU_EARLY_EXIT_EN.
module tb_idr_fu;
   import idr_fu_pkg::*;

   logic        clk_in = 1'b0;
   logic        reset_n = 1'b0;
   logic        flush = 1'b0;
   logic        start = 1'b0;
   IDR_OP_TYPE  op = DIVU;
   logic [31:0] rs1 = '0, rs2 = '0;
   logic [31:0] quotient, remainder;
   logic        done, busy;

   int n_checks = 0;
   int n_pass   = 0;

   idr_fu #(.DW(32)) dut (
      .clk_in(clk_in), .reset_n(reset_n), .flush(flush), .start(start), .op(op),
      .Rs1_data(rs1), .Rs2_data(rs2), .quotient(quotient), .remainder(remainder),
      .done(done), .busy(busy)
   );

   always #5 clk_in = ~clk_in;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   // Expected normal-path latency given the dividend magnitude
   function automatic int norm_lat(input logic [31:0] mag);
`ifdef IDRFU_EARLY_EXIT_EN
      int bits = 0;
      for (int i = 0; i < 32; i++) if (mag[i]) bits = i + 1;
      return (bits == 0) ? 1 : bits + 1;
`else
      return (mag == 32'd0) ? 33 : 33;
`endif
   endfunction

   // Issue one op and wait (bounded) for done; returns in the done cycle
   task automatic do_op(input IDR_OP_TYPE o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [31:0] r,
                        output int lat, output bit busy_ok);
      op = o; rs1 = a; rs2 = b; start = 1'b1;
      tick();
      start = 1'b0;
      lat = 0; busy_ok = 1'b1;
      while (done !== 1'b1 && lat < 100) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         tick();
         lat++;
      end
      q = quotient; r = remainder;
   endtask

   task automatic test_reset();
      n_checks++; if (quotient !== 32'd0) $display("FAIL reset_q got %h want 0", quotient); else n_pass++;
      n_checks++; if (remainder !== 32'd0) $display("FAIL reset_r got %h want 0", remainder); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
   endtask

   task automatic test_divu();
      logic [31:0] q, r; int lat; bit bok;
      do_op(DIVU, 32'd100, 32'd7, q, r, lat, bok);
      n_checks++; if (q !== 32'd14) $display("FAIL divu_q got %0d want 14", q); else n_pass++;
      n_checks++; if (r !== 32'd2) $display("FAIL divu_r got %0d want 2", r); else n_pass++;
      n_checks++; if (lat !== norm_lat(32'd100)) $display("FAIL divu_lat got %0d want %0d", lat, norm_lat(32'd100)); else n_pass++;
      n_checks++; if (!bok || busy !== 1'b0) $display("FAIL divu_busy during=%b at_done=%b want 1/0", bok, busy); else n_pass++;
      tick();
      n_checks++; if (done !== 1'b0) $display("FAIL divu_pulse got %b want 0", done); else n_pass++;
   endtask

   task automatic test_signed();
      IDR_OP_TYPE  ops [4] = '{DIV, REM, DIV, REMU};
      logic [31:0] a   [4] = '{32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
      logic [31:0] b   [4] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd2};
      logic [31:0] eq  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd3, 32'h7FFF_FFFC};
      logic [31:0] er  [4] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd1};
      logic [31:0] mg  [4] = '{32'd7, 32'd7, 32'd7, 32'hFFFF_FFF9};
      logic [31:0] q, r; int lat; bit bok;
      for (int i = 0; i < 4; i++) begin
         do_op(ops[i], a[i], b[i], q, r, lat, bok);
         n_checks++; if (q !== eq[i] || r !== er[i])
            $display("FAIL signed_%0d got q=%h r=%h want q=%h r=%h", i, q, r, eq[i], er[i]); else n_pass++;
         n_checks++; if (lat !== norm_lat(mg[i])) $display("FAIL signed_lat_%0d got %0d want %0d", i, lat, norm_lat(mg[i])); else n_pass++;
         tick();
      end
   endtask

   task automatic test_special();
      IDR_OP_TYPE  ops [4] = '{REMU, DIV, DIV, DIVU};
      logic [31:0] a   [4] = '{32'h1234, 32'h8000_0000, 32'hFFFF_FFFB, 32'h8000_0000};
      logic [31:0] b   [4] = '{32'd0, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF};
      logic [31:0] eq  [4] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
      logic [31:0] er  [4] = '{32'h1234, 32'd0, 32'hFFFF_FFFB, 32'h8000_0000};
      int          el  [4];
      logic [31:0] q, r; int lat; bit bok;
      el = '{1, 1, 1, norm_lat(32'h8000_0000)};
      for (int i = 0; i < 4; i++) begin
         do_op(ops[i], a[i], b[i], q, r, lat, bok);
         n_checks++; if (q !== eq[i] || r !== er[i])
            $display("FAIL special_%0d got q=%h r=%h want q=%h r=%h", i, q, r, eq[i], er[i]); else n_pass++;
         n_checks++; if (lat !== el[i]) $display("FAIL special_lat_%0d got %0d want %0d", i, lat, el[i]); else n_pass++;
         tick();
         n_checks++; if (done !== 1'b0) $display("FAIL special_pulse_%0d got %b want 0", i, done); else n_pass++;
      end
   endtask

   task automatic test_flush();
      logic [31:0] q, r; int lat; bit bok; bit seen;
      do_op(DIVU, 32'd9, 32'd2, q, r, lat, bok);
      tick();
      op = DIVU; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
      tick();
      start = 1'b0;
      for (int e = 1; e < 10; e++) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL flush_idle got busy=%b done=%b want 0/0", busy, done); else n_pass++;
      n_checks++; if (quotient !== 32'd4 || remainder !== 32'd1)
         $display("FAIL flush_hold got q=%0d r=%0d want 4/1", quotient, remainder); else n_pass++;
      seen = 1'b0;
      for (int e = 0; e < 40; e++) begin if (done === 1'b1) seen = 1'b1; tick(); end
      n_checks++; if (seen) $display("FAIL flush_no_done got done=1 want none"); else n_pass++;
      // flush and start together: start dropped
      op = DIVU; rs1 = 32'd50; rs2 = 32'd5; start = 1'b1; flush = 1'b1;
      tick();
      start = 1'b0; flush = 1'b0;
      n_checks++; if (busy !== 1'b0) $display("FAIL flush_prio got busy=%b want 0", busy); else n_pass++;
      seen = 1'b0;
      for (int e = 0; e < 40; e++) begin if (done === 1'b1) seen = 1'b1; tick(); end
      n_checks++; if (seen || quotient !== 32'd4) $display("FAIL flush_prio_done got seen=%b q=%0d want 0/4", seen, quotient); else n_pass++;
   endtask

   task automatic test_reset_mid();
      bit seen;
      op = DIVU; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
      tick();
      start = 1'b0;
      for (int e = 1; e < 10; e++) tick();
      #2 reset_n = 1'b0;
      #1;
      n_checks++; if (quotient !== 32'd0 || remainder !== 32'd0)
         $display("FAIL rstmid_qr got q=%h r=%h want 0/0", quotient, remainder); else n_pass++;
      n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rstmid_flags got busy=%b done=%b want 0/0", busy, done); else n_pass++;
      @(negedge clk_in) reset_n = 1'b1;
      tick();
      seen = 1'b0;
      for (int e = 0; e < 40; e++) begin if (done === 1'b1 || busy === 1'b1) seen = 1'b1; tick(); end
      n_checks++; if (seen) $display("FAIL rstmid_quiet got activity after reset want none"); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] q, r; int lat; bit bok;
      do_op(DIVU, 32'd9, 32'd2, q, r, lat, bok);
      n_checks++; if (q !== 32'd4 || r !== 32'd1) $display("FAIL b2b_first got q=%0d r=%0d want 4/1", q, r); else n_pass++;
      n_checks++; if (lat !== norm_lat(32'd9)) $display("FAIL b2b_first_lat got %0d want %0d", lat, norm_lat(32'd9)); else n_pass++;
      do_op(DIVU, 32'd20, 32'd6, q, r, lat, bok);
      n_checks++; if (q !== 32'd3 || r !== 32'd2) $display("FAIL b2b_second got q=%0d r=%0d want 3/2", q, r); else n_pass++;
      n_checks++; if (lat !== norm_lat(32'd20)) $display("FAIL b2b_second_lat got %0d want %0d", lat, norm_lat(32'd20)); else n_pass++;
      tick();
   endtask

   task automatic test_busy_ignore();
      int lat; bit seen;
      op = DIVU; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
      tick();
      start = 1'b0;
      lat = 0;
      tick(); lat++;
      op = DIVU; rs1 = 32'd50; rs2 = 32'd5; start = 1'b1;
      tick(); lat++;
      start = 1'b0;
      while (done !== 1'b1 && lat < 100) begin tick(); lat++; end
      n_checks++; if (quotient !== 32'd14 || remainder !== 32'd2)
         $display("FAIL ignore_result got q=%0d r=%0d want 14/2", quotient, remainder); else n_pass++;
      n_checks++; if (lat !== norm_lat(32'd100)) $display("FAIL ignore_lat got %0d want %0d", lat, norm_lat(32'd100)); else n_pass++;
      tick();
      seen = 1'b0;
      for (int e = 0; e < 40; e++) begin if (done === 1'b1) seen = 1'b1; tick(); end
      n_checks++; if (seen) $display("FAIL ignore_second got extra done want none"); else n_pass++;
   endtask

   task automatic test_early_exit();
      logic [31:0] q, r; int lat; bit bok;
      do_op(DIVU, 32'd5, 32'd2, q, r, lat, bok);
      n_checks++; if (q !== 32'd2 || r !== 32'd1) $display("FAIL early_5_2 got q=%0d r=%0d want 2/1", q, r); else n_pass++;
`ifdef IDRFU_EARLY_EXIT_EN
      n_checks++; if (lat !== 4) $display("FAIL early_5_2_lat got %0d want 4", lat); else n_pass++;
`else
      n_checks++; if (lat !== 33) $display("FAIL early_5_2_lat got %0d want 33", lat); else n_pass++;
`endif
      tick();
      do_op(DIVU, 32'd0, 32'd9, q, r, lat, bok);
      n_checks++; if (q !== 32'd0 || r !== 32'd0) $display("FAIL early_0_9 got q=%0d r=%0d want 0/0", q, r); else n_pass++;
`ifdef IDRFU_EARLY_EXIT_EN
      n_checks++; if (lat !== 1) $display("FAIL early_0_9_lat got %0d want 1", lat); else n_pass++;
`else
      n_checks++; if (lat !== 33) $display("FAIL early_0_9_lat got %0d want 33", lat); else n_pass++;
`endif
      tick();
   endtask

   initial begin
      tick();
      tick();
      test_reset();
      @(negedge clk_in) reset_n = 1'b1;
      tick();
      test_reset();
      test_divu();
      test_signed();
      test_special();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      test_busy_ignore();
      test_early_exit();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/idr_fu.md
Name: idr_fu

Overview:
Iterative integer divide/remainder functional unit for the RV32M DIV, DIVU, REM and REMU instructions.
- Sits directly downstream of the EXE stage and is the slave side of IDRFU_intf.
- EXE issues one operation with a start pulse, stalls its E2M handshake, and consumes quotient/remainder when done pulses.
- Radix-2 restoring algorithm: one quotient bit per clock, plus fast paths for RISC-V special cases.

Parameters:
- DW, default RSZ (32): operand/result width. Must be ≥ 2.
- CNT_W, default $clog2(DW+1): width of the iteration counter.

Ports:
- clk_in  input  1  : core clock.
- reset_n  input  1  : asynchronous active-low reset. Assertion is asynchronous; release is synchronous to clk_in.
- flush  input  1  : pipeline flush from EXE/WB. Aborts any operation in progress.
- start  input  1  : single-cycle request. Operands and op are sampled at this clock edge.
- op  input  IDR_OP_TYPE : DIV, DIVU, REM, REMU.
- Rs1_data  input  DW  : dividend.
- Rs2_data  input  DW  : divisor.
- quotient  output  DW  : registered quotient.
- remainder  output  DW  : registered remainder.
- done  output  1  : one-cycle pulse; results are valid in that cycle.
- busy  output  1  : 1 whenever state ≠ IDLE.

Behaviour:
Reset values:
- state=IDLE; quotient=0; remainder=0; done=0; busy=0.
- All internal registers (accumulator, divisor magnitude, counter, sign flags) are cleared.

States and transitions:
- IDLE: on start, capture the following.
  - signed_op = (op==DIV or op==REM).
  - neg_q = signed_op & (Rs1[DW-1] ^ Rs2[DW-1]).
  - neg_r = signed_op & Rs1[DW-1].
  - Magnitudes |Rs1| and |Rs2|. Two's-complement negate when signed and MSB set; |0x80000000| = 0x80000000 unsigned.
  - Next state:
    - Rs2==0 → FIX with div-by-zero flag.
    - signed_op & Rs1==2^(DW-1) & Rs2==all-ones → FIX with overflow flag.
    - Otherwise → CALC with counter=DW.
- CALC: each cycle do one restoring step and decrement the counter.
  - Shift the {rem, dividend} pair left by 1.
  - trial = rem - divisor, computed at DW+1 bits.
  - If trial is non-negative, rem = trial and the quotient bit = 1; otherwise the quotient bit = 0.
  - Counter reaching 0 → FIX.
- FIX: register outputs, set done=1, go to IDLE.
  - Normal: quotient = neg_q ? -q : q; remainder = neg_r ? -r : r.
  - Div-by-zero: quotient = all-ones (−1); remainder = Rs1 as given.
  - Overflow: quotient = 2^(DW-1); remainder = 0.

Latency:
- Let edge 0 be the edge that samples start.
- Normal operation: done is high in the cycle after edge DW+1 (edge 33 for DW=32).
- Special cases: done is high in the cycle after edge 1.
- done is high for exactly one cycle.
- quotient/remainder hold their values until the next FIX or reset.

Handshake rules:
- start while busy=1 is ignored; no state change.
- start in the same cycle that done is high is accepted (back-to-back operation).
- Ops use the same datapath. op selects only the sign handling; EXE picks quotient or remainder.

Flush:
- flush=1 forces state=IDLE, done=0, busy=0 on that edge. quotient/remainder are unchanged.
- flush has priority over start in the same cycle: start is dropped.

Reset mid-operation:
- Reset asserted mid-operation immediately forces the reset values; no done is produced.

Optional Feature:
IDRFU_EARLY_EXIT_EN
- When defined, IDLE also computes lz = leading-zero count of |Rs1|.
  - The dividend magnitude is pre-shifted left by lz.
  - The counter is loaded with DW-lz.
- If |Rs1|==0, go directly to FIX with q=0, r=0; done appears after edge 1.
- Normal latency becomes DW-lz+1 edges.
- Results are bit-identical to the non-feature build.
- When undefined, latency is always fixed at DW+1 edges and no lz logic is present.

Test Plan:
- DIVU, Rs1=100, Rs2=7 → quotient=14, remainder=2; done pulses once, after edge 33; busy high from edge 0 to edge 33.
- DIV, Rs1=0xFFFFFFF9 (−7), Rs2=2 → quotient=0xFFFFFFFD (−3), remainder=0xFFFFFFFF (−1). REM with Rs1=7, Rs2=0xFFFFFFFE → remainder=1.
- Divide by zero: REMU, Rs1=0x1234, Rs2=0 → quotient=0xFFFFFFFF, remainder=0x1234, done after edge 1. Signed overflow: DIV, 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0, done after edge 1.
- Mid-operation events:
  - Start DIVU 1000/3, assert flush at edge 10 → no done ever; busy=0 after edge 10; outputs retain the previous result.
  - Repeat with reset_n low at edge 10 → all outputs 0 immediately.
- Back-to-back and busy handling:
  - Issue the second start in the done cycle of the first (DIVU 9/2, then DIVU 20/6) → 4/1 then 3/2, with the second done 33 edges after its start.
  - A start pulsed mid-CALC is ignored.
- With IDRFU_EARLY_EXIT_EN defined:
  - DIVU 5/2 → 2/1 with done after edge 4 (lz=29).
  - DIVU 0/9 → 0/0 after edge 1.
  - Without the macro, both complete after edge 33.
